// File: rtl/regfile_mp_scoreboard.sv
// Two-write/two-read architectural register file with same-cycle bypass and a
// per-register busy scoreboard for pending load destinations.
module regfile_mp_scoreboard #(
    parameter int unsigned  XLEN = 32,
    parameter int unsigned  NREG = 32,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] REG_rs1_data,
    output logic [XLEN-1:0] REG_rs2_data,
    output logic            REG_rs1_busy,
    output logic            REG_rs2_busy,
    input  logic            REG_write_enable,
    input  logic [AW-1:0]   REG_write_address,
    input  logic [XLEN-1:0] REG_write_value,
    input  logic            LD_write_enable,
    input  logic [AW-1:0]   LD_write_address,
    input  logic [XLEN-1:0] LD_write_value,
    input  logic            ISSUE_valid,
    input  logic [AW-1:0]   ISSUE_rd,
    output logic [AW:0]     REG_busy_count,
    output logic            REG_wr_conflict,
    input  logic [AW-1:0]   test_register,
    output logic [XLEN-1:0] value_need_to_test
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     count_q, count_d;
    logic            conflict_q, conflict_d;

    logic wa, wb, set, inc, dec;

    assign wa  = REG_write_enable && (REG_write_address != '0);
    assign wb  = LD_write_enable && (LD_write_address != '0);
    assign set = ISSUE_valid && (ISSUE_rd != '0);

    // A fresh issue onto the returning index keeps the bit set, so no decrement.
    assign inc = set && !busy_q[ISSUE_rd];
    assign dec = wb && busy_q[LD_write_address] && !(set && (ISSUE_rd == LD_write_address));

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            busy_d[i] = busy_q[i];
            if (i != 0) begin
                if (wa && (REG_write_address == AW'(i))) begin
                    regs_d[i] = REG_write_value;
                end else if (wb && (LD_write_address == AW'(i))) begin
                    regs_d[i] = LD_write_value;
                end
                if (set && (ISSUE_rd == AW'(i))) begin
                    busy_d[i] = 1'b1;
                end else if (wb && (LD_write_address == AW'(i))) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
        count_d    = count_q + (AW+1)'(inc) - (AW+1)'(dec);
        conflict_d = conflict_q | (wa && wb && (REG_write_address == LD_write_address));
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            count_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            count_q    <= count_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        REG_rs1_data = regs_q[rs1];
        if (rs1 == '0) begin
            REG_rs1_data = '0;
        end else if (wa && (REG_write_address == rs1)) begin
            REG_rs1_data = REG_write_value;
        end else if (wb && (LD_write_address == rs1)) begin
            REG_rs1_data = LD_write_value;
        end
    end

    always_comb begin
        REG_rs2_data = regs_q[rs2];
        if (rs2 == '0) begin
            REG_rs2_data = '0;
        end else if (wa && (REG_write_address == rs2)) begin
            REG_rs2_data = REG_write_value;
        end else if (wb && (LD_write_address == rs2)) begin
            REG_rs2_data = LD_write_value;
        end
    end

    // A load returning this cycle forwards its data, so it no longer stalls.
    assign REG_rs1_busy = (rs1 != '0) && busy_q[rs1] && !(wb && (LD_write_address == rs1));
    assign REG_rs2_busy = (rs2 != '0) && busy_q[rs2] && !(wb && (LD_write_address == rs2));

    assign REG_busy_count     = count_q;
    assign REG_wr_conflict    = conflict_q;
    assign value_need_to_test = (test_register == '0) ? '0 : regs_q[test_register];

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed scoreboard bench: stimulus queues expected outputs, a monitor
// drains and compares them against the live DUT at each sample strobe.
module tb_regfile_mp_scoreboard;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    localparam int SelRs1D = 0, SelRs2D = 1, SelRs1B = 2, SelRs2B = 3;
    localparam int SelCnt = 4, SelConf = 5, SelDbg = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1, rs2, wa_addr, wb_addr, iss_rd, dbg_idx;
    logic [XLEN-1:0] rs1_data, rs2_data, wa_val, wb_val, dbg_val;
    logic            rs1_busy, rs2_busy, wa_en, wb_en, iss_v, wr_conf;
    logic [AW:0]     busy_cnt;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
        .SYS_clk            (clk),
        .SYS_reset          (rst),
        .rs1                (rs1),
        .rs2                (rs2),
        .REG_rs1_data       (rs1_data),
        .REG_rs2_data       (rs2_data),
        .REG_rs1_busy       (rs1_busy),
        .REG_rs2_busy       (rs2_busy),
        .REG_write_enable   (wa_en),
        .REG_write_address  (wa_addr),
        .REG_write_value    (wa_val),
        .LD_write_enable    (wb_en),
        .LD_write_address   (wb_addr),
        .LD_write_value     (wb_val),
        .ISSUE_valid        (iss_v),
        .ISSUE_rd           (iss_rd),
        .REG_busy_count     (busy_cnt),
        .REG_wr_conflict    (wr_conf),
        .test_register      (dbg_idx),
        .value_need_to_test (dbg_val)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SelRs1D: return rs1_data;
            SelRs2D: return rs2_data;
            SelRs1B: return {31'b0, rs1_busy};
            SelRs2B: return {31'b0, rs2_busy};
            SelCnt:  return {26'b0, busy_cnt};
            SelConf: return {31'b0, wr_conf};
            default: return dbg_val;
        endcase
    endfunction

    // Monitor: drain every queued expectation at each sample strobe.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = observe(e.sel);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = '0; wa_val = '0;
        wb_en = 0; wb_addr = '0; wb_val = '0;
        iss_v = 0; iss_rd  = '0;
    endtask

    // Commit current inputs on the next rising edge, then land on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rs1 = '0; rs2 = '0; dbg_idx = '0;
        idle();
        step();
        step();
        rst = 1'b0;

        // Post-reset: everything reads zero.
        expect_v("reset_count", SelCnt, 0);
        expect_v("reset_conflict", SelConf, 0);
        sample();
        for (int i = 0; i < NREG; i++) begin
            rs1 = AW'(i); rs2 = AW'(i); dbg_idx = AW'(i);
            expect_v($sformatf("reset_rs1_x%0d", i), SelRs1D, 0);
            expect_v($sformatf("reset_rs2_x%0d", i), SelRs2D, 0);
            expect_v($sformatf("reset_busy_x%0d", i), SelRs1B, 0);
            expect_v($sformatf("reset_dbg_x%0d", i), SelDbg, 0);
            sample();
        end

        // Port A write with same-cycle bypass.
        rs1 = 5; dbg_idx = 5;
        wa_en = 1; wa_addr = 5; wa_val = 32'hDEADBEEF;
        expect_v("a_bypass_x5", SelRs1D, 32'hDEADBEEF);
        expect_v("a_dbg_nobypass_x5", SelDbg, 0);
        sample();
        step();
        idle();
        expect_v("a_array_x5", SelRs1D, 32'hDEADBEEF);
        expect_v("a_dbg_x5", SelDbg, 32'hDEADBEEF);
        sample();

        // Writes and issue to x0 are ignored.
        rs1 = 0; dbg_idx = 0;
        wa_en = 1; wa_addr = 0; wa_val = 32'h55;
        wb_en = 1; wb_addr = 0; wb_val = 32'h66;
        iss_v = 1; iss_rd = 0;
        expect_v("x0_bypass", SelRs1D, 0);
        expect_v("x0_busy", SelRs1B, 0);
        sample();
        step();
        idle();
        expect_v("x0_read", SelRs1D, 0);
        expect_v("x0_dbg", SelDbg, 0);
        expect_v("x0_count", SelCnt, 0);
        expect_v("x0_conflict", SelConf, 0);
        sample();

        // A/B same-index conflict: A wins, flag is sticky.
        rs2 = 7; dbg_idx = 7;
        wa_en = 1; wa_addr = 7; wa_val = 32'h11;
        wb_en = 1; wb_addr = 7; wb_val = 32'h22;
        expect_v("conf_bypass_x7", SelRs2D, 32'h11);
        expect_v("conf_flag_pre", SelConf, 0);
        sample();
        step();
        idle();
        expect_v("conf_array_x7", SelRs2D, 32'h11);
        expect_v("conf_dbg_x7", SelDbg, 32'h11);
        expect_v("conf_flag_set", SelConf, 1);
        sample();
        step();
        expect_v("conf_flag_sticky", SelConf, 1);
        sample();

        // Issue x9, then load return clears it.
        rs1 = 9;
        iss_v = 1; iss_rd = 9;
        expect_v("iss9_busy_pre", SelRs1B, 0);
        sample();
        step();
        idle();
        expect_v("iss9_busy", SelRs1B, 1);
        expect_v("iss9_count", SelCnt, 1);
        sample();
        wb_en = 1; wb_addr = 9; wb_val = 32'hCAFE;
        expect_v("ld9_busy_fwd", SelRs1B, 0);
        expect_v("ld9_data_fwd", SelRs1D, 32'hCAFE);
        expect_v("ld9_count_pre", SelCnt, 1);
        sample();
        step();
        idle();
        expect_v("ld9_count", SelCnt, 0);
        expect_v("ld9_busy", SelRs1B, 0);
        expect_v("ld9_data", SelRs1D, 32'hCAFE);
        sample();

        // Same-edge set and clear on x3: set wins.
        rs1 = 3;
        iss_v = 1; iss_rd = 3;
        step();
        idle();
        expect_v("iss3_busy", SelRs1B, 1);
        expect_v("iss3_count", SelCnt, 1);
        sample();
        iss_v = 1; iss_rd = 3;
        wb_en = 1; wb_addr = 3; wb_val = 32'h33;
        expect_v("setclr3_busy_fwd", SelRs1B, 0);
        expect_v("setclr3_data_fwd", SelRs1D, 32'h33);
        sample();
        step();
        idle();
        expect_v("setclr3_busy", SelRs1B, 1);
        expect_v("setclr3_count", SelCnt, 1);
        expect_v("setclr3_data", SelRs1D, 32'h33);
        sample();

        // Re-issue an already-busy index: no count change.
        iss_v = 1; iss_rd = 3;
        step();
        idle();
        expect_v("reiss3_count", SelCnt, 1);
        sample();

        // Set x10 and clear x3 on one edge: net zero.
        rs1 = 10; rs2 = 3;
        iss_v = 1; iss_rd = 10;
        wb_en = 1; wb_addr = 3; wb_val = 32'h3333;
        step();
        idle();
        expect_v("swap_busy_x10", SelRs1B, 1);
        expect_v("swap_busy_x3", SelRs2B, 0);
        expect_v("swap_count", SelCnt, 1);
        expect_v("swap_data_x3", SelRs2D, 32'h3333);
        sample();

        // Port A write does not clear busy.
        wa_en = 1; wa_addr = 10; wa_val = 32'hA0;
        step();
        idle();
        expect_v("a_noclr_busy_x10", SelRs1B, 1);
        expect_v("a_noclr_count", SelCnt, 1);
        sample();

        // Reset mid-load: x4 busy, writes/issue pending at the reset edge.
        rs1 = 4; rs2 = 6; dbg_idx = 5;
        iss_v = 1; iss_rd = 4;
        step();
        idle();
        expect_v("pre_rst_busy_x4", SelRs1B, 1);
        expect_v("pre_rst_count", SelCnt, 2);
        sample();
        rst = 1'b1;
        wa_en = 1; wa_addr = 4; wa_val = 32'h44;
        wb_en = 1; wb_addr = 6; wb_val = 32'h66;
        iss_v = 1; iss_rd = 5;
        step();
        rst = 1'b0;
        idle();
        expect_v("rst_data_x4", SelRs1D, 0);
        expect_v("rst_busy_x4", SelRs1B, 0);
        expect_v("rst_data_x6", SelRs2D, 0);
        expect_v("rst_count", SelCnt, 0);
        expect_v("rst_conflict", SelConf, 0);
        expect_v("rst_dbg_x5", SelDbg, 0);
        sample();
        rs1 = 5;
        expect_v("rst_busy_x5", SelRs1B, 0);
        sample();

        #2;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised successor to the core's architectural register file.
- Two write ports:
  - Port A: in-order ALU writeback.
  - Port B: late load/MMIO return.
- Two combinational read ports with same-cycle write-to-read bypass.
- Per-register busy scoreboard so decode can stall on pending load destinations.
- Sits between decode (reads, issue marking) and writeback/LSU (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; register 0 hardwired to zero.
- AW, $clog2(NREG), register index width (derived, not overridden).

Ports:
- SYS_clk  in  1  clock; all state updates on rising edge.
- SYS_reset  in  1  synchronous active-high reset.
- rs1  in  AW  read index, port 1.
- rs2  in  AW  read index, port 2.
- REG_rs1_data  out  XLEN  bypassed read data, port 1.
- REG_rs2_data  out  XLEN  bypassed read data, port 2.
- REG_rs1_busy  out  1  rs1 has a pending load not resolved this cycle.
- REG_rs2_busy  out  1  same for rs2.
- REG_write_enable  in  1  write port A enable.
- REG_write_address  in  AW  write port A index.
- REG_write_value  in  XLEN  write port A data.
- LD_write_enable  in  1  write port B enable.
- LD_write_address  in  AW  write port B index.
- LD_write_value  in  XLEN  write port B data.
- ISSUE_valid  in  1  a load is issuing this cycle.
- ISSUE_rd  in  AW  destination of the issuing load.
- REG_busy_count  out  AW+1  number of registers currently marked busy.
- REG_wr_conflict  out  1  sticky: A and B wrote the same nonzero index in one cycle.
- test_register  in  AW  debug read index.
- value_need_to_test  out  XLEN  debug read data, array value only, no bypass.

Behaviour:
- Reset (SYS_reset=1 at edge):
  - All NREG registers, busy bits, REG_busy_count and REG_wr_conflict clear to 0.
  - Reset dominates every write and issue in that cycle.
  - Read outputs are combinational. The cycle after reset, every data output reads 0 and every busy output reads 0.
- Register 0:
  - Always reads 0.
  - Writes and issues targeting index 0 are ignored: no array update, no busy set, no conflict.
- Writes (at edge):
  - Port A writes when REG_write_enable && addr!=0.
  - Port B writes when LD_write_enable && addr!=0.
  - Different addresses: both commit.
  - Same nonzero address in one cycle: port A value commits, port B is dropped, REG_wr_conflict sets and stays 1 until reset.
- Read bypass (combinational, zero latency), priority for rsN!=0:
  1. Port A writing rsN this cycle returns REG_write_value.
  2. Else port B writing rsN returns LD_write_value.
  3. Else the array value.
  - rsN==0 returns 0.
- Scoreboard:
  - Busy bit per register.
  - Set at edge when ISSUE_valid && ISSUE_rd!=0.
  - Cleared at edge when port B writes that index. The clear applies even if port B's data was dropped on conflict.
  - Port A writes never clear busy.
  - Same-cycle set and clear on one index: set wins, so the bit stays 1 (new load issued).
  - Issue to an already-busy index: stays 1, no count change.
- REG_rsN_busy = busy[rsN] && !(port B writing rsN this cycle). The returning load forwards, so no stall.
  - rsN==0 gives 0.
- REG_busy_count:
  - Registered.
  - Equals popcount of busy bits after each edge.
  - Updated incrementally: +1 on a new set, −1 on a clear, net 0 when both apply to different indices.
  - Never wraps; range 0..NREG-1.
- value_need_to_test = array[test_register], no bypass, index 0 reads 0.

Test Plan:
- Reset then read all indices → all data 0, busy 0, REG_busy_count=0, REG_wr_conflict=0.
- Port A writes 0xDEADBEEF to x5 while rs1=5 → REG_rs1_data=0xDEADBEEF same cycle; next cycle array and test port read 0xDEADBEEF.
- A writes 0x11 and B writes 0x22 to x7 in the same cycle:
  - rs2=7 reads 0x11 in that cycle.
  - x7 holds 0x11 afterwards.
  - REG_wr_conflict=1 and stays 1 until SYS_reset.
- ISSUE_valid, rd=9:
  - Next cycle REG_rs1_busy=1 for rs1=9 and REG_busy_count=1.
  - Then port B writes 0xCAFE to x9: same cycle busy=0 and data=0xCAFE; next cycle count=0.
- Issue rd=3 on the same edge that port B writes x3 (x3 previously busy) → x3 stays busy, count unchanged.
- Write or issue targeting x0 → x0 reads 0, count unchanged, no conflict.
- Assert SYS_reset mid-load with x4 busy and a write pending → after the edge, x4 reads 0 and is not busy, count=0.
